seqgen_53: RTL and testbench
============================

Name: seqgen_53

Overview:
- Serial byte transmitter: the sending end of the single-bit serial stream consumed by seqdec_53.
- Accepts bytes over a valid/ready handshake and buffers them in a small FIFO.
- Shifts each byte out MSB-first, one bit per clock, with no gaps while data is queued.
- Used as the stimulus source for sequence-detector benches and as the serial driver in the datapath.

Parameters:
- WIDTH, 8: bits per symbol shifted out.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- IDLE_BIT, 1'b0: value driven on Out when no symbol is being shifted.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- InData  in  WIDTH  byte to transmit.
- InValid  in  1  InData is valid.
- InReady  out  1  FIFO can accept a byte this cycle.
- Out  out  1  serial data bit; registered.
- OutValid  out  1  Out carries a real data bit; registered.
- ByteStart  out  1  high during the first (MSB) bit of each byte; registered.
- Busy  out  1  shifter active or FIFO non-empty.
- Count  out  $clog2(DEPTH+1)  FIFO occupancy; excludes the byte in the shifter.

Behaviour:
- Reset asserted (Reset==0), taking effect immediately:
  - FIFO emptied; shifter and bit counter cleared.
  - Out=IDLE_BIT, OutValid=0, ByteStart=0, Busy=0, Count=0, InReady=1.
- Reset released: normal operation from the next rising edge.
- Handshake:
  - InReady = (Count != DEPTH), combinational from occupancy.
  - A byte is accepted at a rising edge where InValid && InReady.
  - InData is sampled only on that edge.
  - No acceptance while full, even if a pop happens the same edge; keeps InReady free of pop logic.
- Shifter states:
  - IDLE: OutValid=0, Out=IDLE_BIT. On an edge with Count>0: pop FIFO head into the shift register and go to SHIFT. Out=head[WIDTH-1], OutValid=1, ByteStart=1, bitcnt=WIDTH-1.
  - SHIFT, bitcnt>0: shift left. Out=next bit, ByteStart=0, bitcnt decrements.
  - SHIFT, bitcnt==0 (last bit currently on Out):
    - Count>0: pop and load the next byte on the same edge, so the stream is continuous; ByteStart=1 again.
    - Count==0: return to IDLE; Out=IDLE_BIT, OutValid=0.
- Latency: a byte accepted at edge N into an empty, idle block drives its MSB on Out from edge N+1. A byte pushed and popped on the same edge is not allowed (it must sit in the FIFO for one edge).
- Simultaneous push and pop: legal when not full. Count stays the same; FIFO pointers wrap modulo DEPTH.
- Busy = (state==SHIFT) || (Count!=0).
- Reset mid-byte: the partial byte and all queued bytes are discarded; the stream resumes only with newly accepted bytes.
- InData changes while InValid=0 or InReady=0 have no effect.

Decomposition:
- Shared package seqgen_pkg:
  - Default WIDTH/DEPTH constants.
  - IDLE_BIT constant.
  - Shifter state enum {IDLE, SHIFT}.
- Sub-module seqgen_fifo: synchronous FIFO parameterised WIDTH/DEPTH.
  - Inputs: push, pop.
  - Outputs: head, count, full, empty.
  - Same Clk/Reset convention.
- Top level holds the shifter, bit counter and output registers.

Test Plan:
- Reset, then idle 10 cycles -> Out=0, OutValid=0, InReady=1, Count=0, Busy=0 throughout.
- Push 0x53 once into an idle block -> from the next edge Out = 0,1,0,1,0,0,1,1 over 8 cycles, ByteStart only on cycle 1, then OutValid=0.
- Push 0x85,0x97,0x42,0x53,0x28 back-to-back:
  - 40 consecutive valid bits, MSB-first, no gaps.
  - A connected seqdec_53 asserts Out exactly once, aligned to the 0x53 byte.
- Push 5 bytes with DEPTH=4 while the shifter is busy -> InReady drops when Count=4; the 5th byte is held and accepted on the first edge after a pop; all 5 bytes are emitted in order.
- Drive Reset low mid-way through bit 3 of 0xA5 with 2 bytes queued -> outputs go to reset values immediately, Count=0; after release with no pushes, Out stays IDLE_BIT.
- Push and pop on the same edge at Count=2, repeated for 16 bytes -> Count stays 2, pointers wrap, byte order is preserved.

Source files
------------

// File: rtl/seqgen_pkg.sv
// Shared definitions for the seqgen serial byte transmitter.
//   SEQGEN_WIDTH    default bits per symbol
//   SEQGEN_DEPTH    default FIFO entries (power of two, >= 2)
//   SEQGEN_IDLE_BIT line level while nothing is being shifted
//   shift_state_e   shifter state encoding
package seqgen_pkg;

   localparam int   SEQGEN_WIDTH    = 8;
   localparam int   SEQGEN_DEPTH    = 4;
   localparam logic SEQGEN_IDLE_BIT = 1'b0;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } shift_state_e;

endpackage

// File: rtl/seqgen_fifo.sv
// Synchronous FIFO feeding the seqgen shifter.
//   Clk    in   system clock
//   Reset  in   async active-low reset; empties the FIFO
//   push   in   write din at the rising edge (ignored when full)
//   pop    in   drop the head entry at the rising edge (ignored when empty)
//   din    in   WIDTH data to write
//   head   out  oldest entry (valid when !empty)
//   count  out  occupancy, 0..DEPTH
//   full   out  count == DEPTH
//   empty  out  count == 0
module seqgen_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           head,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok, pop_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr_q];
   assign count   = count_q;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: nothing is read until count says it was written.
   always_ff @(posedge Clk) begin
      if (push_ok) mem[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/seqgen_53.sv
// Serial byte transmitter: buffers bytes from a valid/ready handshake and
// shifts them out MSB-first, one bit per clock, back-to-back while queued.
//   Clk        in   system clock
//   Reset      in   async active-low reset
//   InData     in   byte to transmit
//   InValid    in   InData valid
//   InReady    out  FIFO can accept a byte this cycle
//   Out        out  serial bit (registered)
//   OutValid   out  Out carries a data bit (registered)
//   ByteStart  out  first (MSB) bit of a byte on Out (registered)
//   Busy       out  shifter active or FIFO non-empty
//   Count      out  FIFO occupancy, excluding the byte in the shifter
//
// state    | meaning
// ST_IDLE  | line at IDLE_BIT, waiting for a queued byte
// ST_SHIFT | a byte is on the line; bitcnt = bits left after the current one
module seqgen_53
   import seqgen_pkg::*;
#(
   parameter int   WIDTH    = SEQGEN_WIDTH,
   parameter int   DEPTH    = SEQGEN_DEPTH,
   parameter logic IDLE_BIT = SEQGEN_IDLE_BIT
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic [WIDTH-1:0]           InData,
   input  logic                       InValid,
   output logic                       InReady,
   output logic                       Out,
   output logic                       OutValid,
   output logic                       ByteStart,
   output logic                       Busy,
   output logic [$clog2(DEPTH+1)-1:0] Count
);

   localparam int BW = $clog2(WIDTH);
   localparam int CW = $clog2(DEPTH+1);

   shift_state_e     state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [BW-1:0]    bitcnt_q, bitcnt_d;
   logic             out_valid_q, out_valid_d;
   logic             byte_start_q, byte_start_d;

   logic             fifo_push, fifo_pop;
   logic [WIDTH-1:0] fifo_head;
   logic [CW-1:0]    fifo_count;
   logic             fifo_full, fifo_empty;

   // Acceptance depends only on occupancy: a full FIFO refuses even when a
   // pop lands on the same edge, so InReady has no path from the shifter.
   assign InReady   = !fifo_full;
   assign fifo_push = InValid && !fifo_full;

   seqgen_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .Clk   (Clk),
      .Reset (Reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (InData),
      .head  (fifo_head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Out is the shift register MSB; idle fills keep the line at IDLE_BIT.
   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      bitcnt_d     = bitcnt_q;
      out_valid_d  = out_valid_q;
      byte_start_d = 1'b0;
      fifo_pop     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop     = 1'b1;
               state_d      = ST_SHIFT;
               shreg_d      = fifo_head;
               bitcnt_d     = BW'(WIDTH-1);
               out_valid_d  = 1'b1;
               byte_start_d = 1'b1;
            end else begin
               shreg_d     = {WIDTH{IDLE_BIT}};
               out_valid_d = 1'b0;
            end
         end
         ST_SHIFT: begin
            if (bitcnt_q != '0) begin
               shreg_d  = {shreg_q[WIDTH-2:0], IDLE_BIT};
               bitcnt_d = bitcnt_q - BW'(1);
            end else if (!fifo_empty) begin
               // Reload on the last-bit edge so the stream has no gap.
               fifo_pop     = 1'b1;
               shreg_d      = fifo_head;
               bitcnt_d     = BW'(WIDTH-1);
               out_valid_d  = 1'b1;
               byte_start_d = 1'b1;
            end else begin
               state_d     = ST_IDLE;
               shreg_d     = {WIDTH{IDLE_BIT}};
               out_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            shreg_d     = {WIDTH{IDLE_BIT}};
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q      <= ST_IDLE;
         shreg_q      <= {WIDTH{IDLE_BIT}};
         bitcnt_q     <= '0;
         out_valid_q  <= 1'b0;
         byte_start_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         bitcnt_q     <= bitcnt_d;
         out_valid_q  <= out_valid_d;
         byte_start_q <= byte_start_d;
      end
   end

   assign Out       = shreg_q[WIDTH-1];
   assign OutValid  = out_valid_q;
   assign ByteStart = byte_start_q;
   assign Count     = fifo_count;
   assign Busy      = (state_q == ST_SHIFT) || (fifo_count != '0);

endmodule

// File: tb/tb_seqgen_53.sv
// Directed bench for seqgen_53: reset/idle values, single-byte latency,
// back-to-back streaming, FIFO-full back-pressure, mid-byte reset and
// steady push/pop at constant occupancy.
module tb_seqgen_53;

   localparam int W  = 8;
   localparam int D  = 4;
   localparam int CW = $clog2(D+1);

   logic          Clk = 1'b0;
   logic          Reset;
   logic [W-1:0]  InData;
   logic          InValid;
   logic          InReady;
   logic          Out;
   logic          OutValid;
   logic          ByteStart;
   logic          Busy;
   logic [CW-1:0] Count;

   seqgen_53 dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .InData    (InData),
      .InValid   (InValid),
      .InReady   (InReady),
      .Out       (Out),
      .OutValid  (OutValid),
      .ByteStart (ByteStart),
      .Busy      (Busy),
      .Count     (Count)
   );

   always #5 Clk = ~Clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic       rec_en = 1'b0;
   logic       ov_q[$];
   logic       out_q[$];
   logic       bs_q[$];
   logic [7:0] exp_q[$];

   always @(negedge Clk) begin
      if (rec_en) begin
         ov_q.push_back(OutValid);
         out_q.push_back(Out);
         bs_q.push_back(ByteStart);
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic rec_start();
      #1;
      ov_q.delete();
      out_q.delete();
      bs_q.delete();
      rec_en = 1'b1;
   endtask

   // Returns right after the accepting rising edge; waits = refused edges.
   task automatic push_byte(input logic [7:0] b, output int waits);
      logic rdy;
      waits = 0;
      @(negedge Clk);
      InData  = b;
      InValid = 1'b1;
      for (int g = 0; g < 64; g++) begin
         rdy = InReady;
         @(posedge Clk);
         if (rdy) return;
         waits++;
         @(negedge Clk);
      end
      chk("push_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle();
      for (int g = 0; g < 200; g++) begin
         @(negedge Clk);
         if (!Busy && !OutValid) return;
      end
      chk("idle_timeout", 32'd0, 32'd1);
   endtask

   // Expects exp_q as one gap-free MSB-first run, ByteStart on each MSB,
   // followed by OutValid low.
   task automatic check_stream(input string tag, input int nbytes);
      int first;
      int idx;
      logic [7:0] eb;
      first = -1;
      foreach (ov_q[i]) if (first < 0 && ov_q[i]) first = i;
      chk({tag, "_start"}, 32'(first >= 0), 32'd1);
      if (first < 0) return;
      for (int b = 0; b < nbytes; b++) begin
         eb = exp_q[b];
         for (int k = 0; k < W; k++) begin
            idx = first + b*W + k;
            if (idx >= ov_q.size()) begin
               chk({tag, "_short"}, 32'(idx), 32'(ov_q.size()));
               return;
            end
            chk($sformatf("%s_b%0d_k%0d", tag, b, k),
                {29'd0, ov_q[idx], bs_q[idx], out_q[idx]},
                {29'd0, 1'b1, (k == 0), eb[W-1-k]});
         end
      end
      idx = first + nbytes*W;
      if (idx < ov_q.size()) chk({tag, "_tail"}, 32'(ov_q[idx]), 32'd0);
      else                   chk({tag, "_tail_short"}, 32'(idx), 32'(ov_q.size()));
   endtask

   initial begin
      int         w;
      logic [7:0] a5;
      Reset   = 1'b0;
      InValid = 1'b0;
      InData  = '0;

      // Reset values
      #3;
      chk("rst_vals", {25'd0, Out, OutValid, ByteStart, Busy, InReady, Count},
                      {25'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0});
      @(negedge Clk);
      Reset = 1'b1;

      // Idle for 10 cycles
      for (int i = 0; i < 10; i++) begin
         @(negedge Clk);
         chk($sformatf("idle_%0d", i), {25'd0, Out, OutValid, InReady, Count, Busy},
                                       {25'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0});
      end

      // Single byte 0x53: MSB appears one edge after acceptance
      rec_start();
      push_byte(8'h53, w);
      chk("single_wait", 32'(w), 32'd0);
      @(negedge Clk);
      InValid = 1'b0;
      chk("single_n0", {28'd0, OutValid, Count}, {28'd0, 1'b0, 3'd1});
      chk("single_busy", 32'(Busy), 32'd1);
      @(negedge Clk);
      chk("single_n1", {27'd0, OutValid, ByteStart, Out, Count[1:0]},
                       {27'd0, 1'b1, 1'b1, 1'b0, 2'd0});
      repeat (12) @(negedge Clk);
      #1 rec_en = 1'b0;
      exp_q = '{8'h53};
      check_stream("single", 1);

      // Back-to-back bytes: 40 continuous bits
      wait_idle();
      rec_start();
      exp_q = '{8'h85, 8'h97, 8'h42, 8'h53, 8'h28};
      foreach (exp_q[i]) begin
         push_byte(exp_q[i], w);
         chk($sformatf("b2b_wait%0d", i), 32'(w), 32'd0);
      end
      @(negedge Clk);
      InValid = 1'b0;
      repeat (45) @(negedge Clk);
      #1 rec_en = 1'b0;
      check_stream("b2b", 5);

      // Back-pressure: fill to DEPTH while shifting, sixth byte stalls
      wait_idle();
      rec_start();
      exp_q = '{8'hF0, 8'h0F, 8'h3C, 8'hC3, 8'h81, 8'h7E};
      for (int i = 0; i < 5; i++) begin
         push_byte(exp_q[i], w);
         chk($sformatf("full_wait%0d", i), 32'(w), 32'd0);
      end
      #1;
      chk("full_state", {28'd0, InReady, Count}, {28'd0, 1'b0, 3'd4});
      push_byte(exp_q[5], w);
      chk("full_stall", 32'(w), 32'd5);
      @(negedge Clk);
      InValid = 1'b0;
      repeat (60) @(negedge Clk);
      #1 rec_en = 1'b0;
      check_stream("full", 6);

      // Reset in the middle of 0xA5 with two bytes queued
      wait_idle();
      a5 = 8'hA5;
      push_byte(a5, w);
      push_byte(8'h11, w);
      push_byte(8'h22, w);
      @(negedge Clk);
      InValid = 1'b0;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      chk("rstmid_pre", {27'd0, OutValid, Out, Count}, {27'd0, 1'b1, a5[3], 3'd2});
      Reset = 1'b0;
      #1;
      chk("rstmid_now", {25'd0, Out, OutValid, ByteStart, Busy, InReady, Count},
                        {25'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0});
      @(negedge Clk);
      Reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge Clk);
         chk($sformatf("rstmid_idle%0d", i), {27'd0, Out, OutValid, Count, Busy},
                                             {27'd0, 1'b0, 1'b0, 3'd0, 1'b0});
      end

      // Push on every pop edge at occupancy 2 for 16 bytes
      rec_start();
      exp_q.delete();
      for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h10 + i*37));
      for (int i = 0; i < 3; i++) push_byte(exp_q[i], w);
      #1;
      chk("pp_count_init", 32'(Count), 32'd2);
      for (int i = 3; i < 16; i++) begin
         @(negedge Clk);
         InValid = 1'b0;
         repeat ((i == 3) ? 6 : 7) @(posedge Clk);
         push_byte(exp_q[i], w);
         #1;
         chk($sformatf("pp_count%0d", i), {28'd0, w[0], Count}, {28'd0, 1'b0, 3'd2});
      end
      @(negedge Clk);
      InValid = 1'b0;
      repeat (30) @(negedge Clk);
      #1 rec_en = 1'b0;
      check_stream("pp", 16);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
